// File: rtl/net_router_switch_unit_rr.sv
// N-input to 1-output router switch unit: a round-robin arbiter feeding a small
// registered output queue, so input grants never see downstream backpressure.
module net_router_switch_unit_rr #(
   parameter int p_msg_nbits   = 44,
   parameter int p_num_inputs  = 3,
   parameter int p_queue_depth = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [p_msg_nbits-1:0]  i_istream_msg [p_num_inputs],
   input  logic [p_num_inputs-1:0] i_istream_val,
   output logic [p_num_inputs-1:0] o_istream_rdy,
   output logic [p_msg_nbits-1:0]  o_ostream_msg,
   output logic                    o_ostream_val,
   input  logic                    i_ostream_rdy
);

   localparam int PW = $clog2(p_num_inputs);
   localparam int QW = $clog2(p_queue_depth);
   localparam int CW = QW + 1;

   logic [PW-1:0]          r_ptr;
   logic [QW-1:0]          r_head;
   logic [QW-1:0]          r_tail;
   logic [CW-1:0]          r_count;
   logic [p_msg_nbits-1:0] r_storage [p_queue_depth];

   logic [PW-1:0]          w_grant;
   logic                   w_anyVal;
   logic                   w_notFull;
   logic                   w_enq;
   logic                   w_deq;

   // Scan from the highest offset down so the input closest to r_ptr wins.
   always_comb begin
      logic [PW:0] sum;
      w_anyVal = 1'b0;
      w_grant  = '0;
      sum      = '0;
      for (int i = p_num_inputs - 1; i >= 0; i--) begin
         sum = {1'b0, r_ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(p_num_inputs))
            sum = sum - (PW+1)'(p_num_inputs);
         if (i_istream_val[sum[PW-1:0]]) begin
            w_anyVal = 1'b1;
            w_grant  = sum[PW-1:0];
         end
      end
   end

   assign w_notFull     = (r_count < CW'(p_queue_depth));
   assign w_enq         = rst_n && w_anyVal && w_notFull;
   assign w_deq         = o_ostream_val && i_ostream_rdy;
   assign o_ostream_val = (r_count != '0);
   assign o_ostream_msg = o_ostream_val ? r_storage[r_head] : '0;

   // Ready comes only from registered occupancy; a full queue refuses even when draining.
   always_comb begin
      o_istream_rdy = '0;
      if (w_enq)
         o_istream_rdy[w_grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) begin
            r_tail <= r_tail + 1'b1;
            r_ptr  <= (w_grant == PW'(p_num_inputs - 1)) ? '0 : w_grant + 1'b1;
         end
         if (w_deq)
            r_head <= r_head + 1'b1;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (w_enq)
         r_storage[r_tail] <= i_istream_msg[w_grant];
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (!rst_n)
      (o_ostream_val && !i_ostream_rdy) |=> $stable(o_ostream_msg));
   assert property (@(posedge clk) disable iff (!rst_n)
      (r_count == CW'(p_queue_depth)) |-> (o_istream_rdy == '0));
`endif

endmodule

// File: tb/tb_net_router_switch_unit_rr.sv
// Bench for net_router_switch_unit_rr: two configurations (3x2 and 5x4) checked
// every cycle against a queue-based model, plus directed literal scenarios.
module tb_net_router_switch_unit_rr;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [43:0] msgA [3];
   logic [2:0]  valA;
   logic [2:0]  rdyA;
   logic [43:0] omsgA;
   logic        ovalA;
   logic        ordyA;

   logic [43:0] msgB [5];
   logic [4:0]  valB;
   logic [4:0]  rdyB;
   logic [43:0] omsgB;
   logic        ovalB;
   logic        ordyB;

   int nChecks = 0;
   int nFails  = 0;

   logic [43:0] qA [$];
   logic [43:0] qB [$];
   int          mPtrA = 0;
   int          mPtrB = 0;

   always #5 clk = ~clk;

   net_router_switch_unit_rr #(.p_msg_nbits(44), .p_num_inputs(3), .p_queue_depth(2)) dutA (
      .clk(clk), .rst_n(rst_n),
      .i_istream_msg(msgA), .i_istream_val(valA), .o_istream_rdy(rdyA),
      .o_ostream_msg(omsgA), .o_ostream_val(ovalA), .i_ostream_rdy(ordyA)
   );

   net_router_switch_unit_rr #(.p_msg_nbits(44), .p_num_inputs(5), .p_queue_depth(4)) dutB (
      .clk(clk), .rst_n(rst_n),
      .i_istream_msg(msgB), .i_istream_val(valB), .o_istream_rdy(rdyB),
      .o_ostream_msg(omsgB), .o_ostream_val(ovalB), .i_ostream_rdy(ordyB)
   );

   function automatic int grantOf(input logic [7:0] v, input int n, input int p);
      for (int i = 0; i < n; i++) begin
         int k;
         k = (p + i) % n;
         if (v[k]) return k;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [2:0] va, input logic ra);
      valA  = va;
      ordyA = ra;
   endtask

   task automatic doReset();
      step();
      applyStimulus(3'b000, 1'b0);
      valB  = '0;
      ordyB = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   always @(negedge rst_n) begin
      qA.delete();
      qB.delete();
      mPtrA = 0;
      mPtrB = 0;
   end

   // Reference model advances on each rising edge using the inputs held across it.
   always @(posedge clk) begin
      int  g;
      bit  enq;
      bit  deq;
      if (!rst_n) begin
         qA.delete();
         qB.delete();
         mPtrA = 0;
         mPtrB = 0;
      end else begin
         g   = grantOf(8'(valA), 3, mPtrA);
         enq = (g >= 0) && (qA.size() < 2);
         deq = (qA.size() != 0) && ordyA;
         if (deq) void'(qA.pop_front());
         if (enq) begin
            qA.push_back(msgA[g]);
            mPtrA = (g + 1) % 3;
         end
         g   = grantOf(8'(valB), 5, mPtrB);
         enq = (g >= 0) && (qB.size() < 4);
         deq = (qB.size() != 0) && ordyB;
         if (deq) void'(qB.pop_front());
         if (enq) begin
            qB.push_back(msgB[g]);
            mPtrB = (g + 1) % 5;
         end
      end
   end

   // Compare both DUTs against the model mid-cycle.
   always @(negedge clk) begin
      int          g;
      logic [63:0] er;
      g  = grantOf(8'(valA), 3, mPtrA);
      er = '0;
      if (rst_n && g >= 0 && qA.size() < 2) er = 64'(1) << g;
      checkOutput("modelRdyA", 64'(rdyA), er);
      checkOutput("modelValA", 64'(ovalA), 64'(qA.size() != 0));
      checkOutput("modelMsgA", 64'(omsgA), (qA.size() != 0) ? 64'(qA[0]) : 64'(0));
      g  = grantOf(8'(valB), 5, mPtrB);
      er = '0;
      if (rst_n && g >= 0 && qB.size() < 4) er = 64'(1) << g;
      checkOutput("modelRdyB", 64'(rdyB), er);
      checkOutput("modelValB", 64'(ovalB), 64'(qB.size() != 0));
      checkOutput("modelMsgB", 64'(omsgB), (qB.size() != 0) ? 64'(qB[0]) : 64'(0));
   end

   initial begin
      rst_n = 1'b0;
      for (int j = 0; j < 3; j++) msgA[j] = '0;
      for (int j = 0; j < 5; j++) msgB[j] = '0;
      applyStimulus(3'b111, 1'b0);
      valB  = '0;
      ordyB = 1'b0;

      // Reset held with every input valid.
      settle();
      checkOutput("rstRdy", 64'(rdyA), 64'h0);
      checkOutput("rstVal", 64'(ovalA), 64'h0);
      checkOutput("rstMsg", 64'(omsgA), 64'h0);
      step();
      rst_n = 1'b1;
      settle();
      checkOutput("firstGrant", 64'(rdyA), 64'b001);

      // Single source on input 1, three back-to-back messages.
      doReset();
      applyStimulus(3'b010, 1'b1);
      msgA[1] = 44'h0A1;
      settle();
      checkOutput("ssRdy0", 64'(rdyA), 64'b010);
      checkOutput("ssVal0", 64'(ovalA), 64'h0);
      step();
      msgA[1] = 44'h0A2;
      settle();
      checkOutput("ssMsg1", 64'(omsgA), 64'h0A1);
      checkOutput("ssRdy1", 64'(rdyA), 64'b010);
      step();
      msgA[1] = 44'h0A3;
      settle();
      checkOutput("ssMsg2", 64'(omsgA), 64'h0A2);
      step();
      applyStimulus(3'b000, 1'b1);
      settle();
      checkOutput("ssMsg3", 64'(omsgA), 64'h0A3);
      step();
      settle();
      checkOutput("ssDrained", 64'(ovalA), 64'h0);

      // Contention: all three valid, sources must rotate 0,1,2,0,1,2.
      doReset();
      applyStimulus(3'b111, 1'b1);
      for (int j = 0; j < 3; j++) msgA[j] = 44'((j << 8) | 0);
      for (int c = 1; c <= 6; c++) begin
         step();
         for (int j = 0; j < 3; j++) msgA[j] = 44'((j << 8) | c);
         settle();
         checkOutput("rrSrcA", 64'(omsgA[11:8]), 64'((c - 1) % 3));
         checkOutput("rrSeqA", 64'(omsgA[7:0]), 64'(c - 1));
      end
      applyStimulus(3'b000, 1'b0);

      // Backpressure on the depth-2 queue with inputs 0 and 2 valid.
      doReset();
      applyStimulus(3'b101, 1'b0);
      msgA[0] = 44'h0B0;
      msgA[2] = 44'h0B2;
      settle();
      checkOutput("bpRdy0", 64'(rdyA), 64'b001);
      step();
      settle();
      checkOutput("bpRdy1", 64'(rdyA), 64'b100);
      checkOutput("bpMsg1", 64'(omsgA), 64'h0B0);
      step();
      settle();
      checkOutput("bpFullRdy", 64'(rdyA), 64'b000);
      checkOutput("bpFullVal", 64'(ovalA), 64'h1);
      step();
      ordyA = 1'b1;
      settle();
      checkOutput("bpNoBypass", 64'(rdyA), 64'b000);
      step();
      ordyA = 1'b0;
      settle();
      checkOutput("bpResume", 64'(rdyA), 64'b001);
      checkOutput("bpHead", 64'(omsgA), 64'h0B2);
      step();
      settle();
      checkOutput("bpRefull", 64'(rdyA), 64'b000);

      // Asynchronous reset between edges with two messages queued.
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncVal", 64'(ovalA), 64'h0);
      checkOutput("asyncMsg", 64'(omsgA), 64'h0);
      checkOutput("asyncRdy", 64'(rdyA), 64'h0);
      step();
      rst_n = 1'b1;
      applyStimulus(3'b000, 1'b1);
      settle();
      checkOutput("noStale0", 64'(ovalA), 64'h0);
      step();
      settle();
      checkOutput("noStale1", 64'(ovalA), 64'h0);

      // Five inputs, depth 4: pointer wraps 4->0 and queue pointers wrap.
      doReset();
      valB  = 5'b11111;
      ordyB = 1'b1;
      for (int j = 0; j < 5; j++) msgB[j] = 44'((j << 8) | 0);
      for (int c = 1; c <= 9; c++) begin
         step();
         for (int j = 0; j < 5; j++) msgB[j] = 44'((j << 8) | c);
         settle();
         checkOutput("rrSrcB", 64'(omsgB[11:8]), 64'((c - 1) % 5));
      end

      // Randomized traffic on both configurations.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         step();
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
         applyStimulus(3'($urandom()), ($urandom_range(0, 3) != 0) ^ (cyc[9] == 1'b1));
         valB  = 5'($urandom()) & 5'($urandom());
         ordyB = ($urandom_range(0, 2) != 0) ^ (cyc[8] == 1'b1);
         for (int j = 0; j < 3; j++) msgA[j] = {12'($urandom()), $urandom()};
         for (int j = 0; j < 5; j++) msgB[j] = {12'($urandom()), $urandom()};
      end
      settle();

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/net_router_switch_unit_rr.md
# net_router_switch_unit_rr

Parametrised N-input to 1-output switch unit for the ring-network router, replacing the fixed-priority, purely combinational switch stage. It arbitrates among `p_num_inputs` val/rdy input streams with a fair round-robin arbiter. Winning messages are registered into a small output queue, which decouples input grants from downstream backpressure. The block sits between the router's input queues and one output port (west, east, or terminal).

## Interface
- `p_msg_nbits`, 44, network message width in bits.
- `p_num_inputs`, 3, number of input streams; legal range 2..8.
- `p_queue_depth`, 2, output queue entries; power of two, ≥2.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; asserting low clears state immediately; deassertion is synchronous to `clk` upstream.
- `istream_msg[p_num_inputs]`  in  p_msg_nbits each  input messages.
- `istream_val[p_num_inputs]`  in  1 each  input valid.
- `istream_rdy[p_num_inputs]`  out  1 each  input ready; at most one high per cycle.
- `ostream_msg`  out  p_msg_nbits  head-of-queue message.
- `ostream_val`  out  1  queue non-empty.
- `ostream_rdy`  in  1  downstream ready.

## Operation
State:
- Priority pointer `ptr`: $clog2(p_num_inputs) bits.
- Queue storage: p_queue_depth × p_msg_nbits.
- Head pointer and tail pointer: $clog2(p_queue_depth) bits each; wrap modulo depth.
- Occupancy `count`: $clog2(p_queue_depth)+1 bits.

Arbitration (combinational):
- Search inputs starting at index `ptr`, ascending, wrapping modulo p_num_inputs.
- The first input with `istream_val` high is the grant `g`.
- If no input is valid, there is no grant and every `istream_rdy` is 0.

Ready generation:
- `istream_rdy[g]` = (`count` < p_queue_depth).
- Every other `istream_rdy` is 0.
- Ready depends only on registered `count`, never on `ostream_rdy`; there is no combinational path from the output side to the input side.

Enqueue (fires when `istream_val[g]` and `istream_rdy[g]`):
- Write `istream_msg[g]` at the tail.
- Tail advances by 1 with wrap.
- `ptr` ← (g+1) mod p_num_inputs; the modulo applies even when p_num_inputs is not a power of two.
- If no enqueue fires, `ptr` holds.

Dequeue (fires when `ostream_val` and `ostream_rdy`):
- Head advances by 1 with wrap.

Occupancy update:
- Enqueue only: `count` +1.
- Dequeue only: `count` −1.
- Both: unchanged.

Output:
- `ostream_val` = (`count` != 0).
- `ostream_msg` = storage[head] when `ostream_val` is high, else all zeros.

Boundaries:
- Full (`count` = depth): all ready signals are 0, even when a dequeue fires in the same cycle (no full-bypass). Input acceptance resumes the cycle after the dequeue.
- Empty: `ostream_val` = 0. There is no input-to-output bypass.
- Simultaneous enqueue and dequeue while non-full and non-empty: both fire.
- Messages pass through unmodified; arrival order within each input is preserved.
- Assertions (simulation only):
  - `ostream_msg` stays stable while `ostream_val` is high and `ostream_rdy` is low.
  - No input is granted while the queue is full.

## Timing
- Reset values: `ptr`=0, head=0, tail=0, `count`=0, `ostream_val`=0, `ostream_msg`=0, all `istream_rdy`=0 (queue empty, so ready follows `istream_val` after reset releases). Storage is not reset.
- Reset asserted mid-operation:
  - All queued messages are dropped.
  - Outputs take their reset values asynchronously, within the same cycle.
- Latency: a message accepted at edge k is visible on `ostream_*` from edge k onward. That is one cycle from the input handshake to output valid; output is registered.
- Throughput: one message per cycle sustained when `ostream_rdy` is held high and depth ≥2.
- Fairness: with all inputs continuously valid, grants rotate 0,1,…,N−1,0,… ; each input waits at most N−1 grants.
- Trace: one character per cycle per the team's trace scheme. Number of valid inputs: 0→' ', 1→'.', 2→':', ≥3→'#'.

## Test plan
- Reset: hold `reset`=0 with all `istream_val`=1 → all rdy=0, `ostream_val`=0, `ostream_msg`=0. Release reset → input 0 granted first.
- Single source, N=3: input 1 sends 0x0A1, 0x0A2, 0x0A3 back-to-back with `ostream_rdy`=1 → outputs appear in order, one per cycle, first one cycle after acceptance.
- Contention, N=3: all inputs always valid with distinct tagged messages, `ostream_rdy`=1 → output source sequence 0,1,2,0,1,2 over six cycles.
- Backpressure, depth=2: `ostream_rdy`=0 with inputs 0 and 2 valid → two messages accepted, then all rdy=0. Raise `ostream_rdy` for one cycle → one dequeue, rdy returns the next cycle, granted input follows `ptr`.
- Simultaneous enqueue/dequeue at `count`=1 → `count` stays 1, message order preserved. Repeat with p_num_inputs=5 and p_queue_depth=4 to check pointer wrap 4→0 and head/tail wrap.
- Mid-stream reset: assert `reset` low asynchronously between clock edges with `count`=2 → `ostream_val` drops immediately. After release, no stale message is emitted.
